// File: rtl/amo_controller.sv
// ============================================================================
//  Module      : amo_controller
//  Description : Sequencer for RV32 atomic memory operations (AMO*.W) and,
//                when RS5_ZALRSC_EN is defined, load-reserved /
//                store-conditional with a single word reservation.
//                Issues one read and/or one write on a simple req/ack bus
//                and returns the rd value with a one-cycle done pulse.
//  Config      : `define RS5_ZALRSC_EN enables LR.W / SC.W support.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amo_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  kind_i,
  input  logic [9:0]  amo_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  input  logic        resv_clear_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_READ  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_RESP  = 2'd3;

  localparam logic [1:0] C_AMO = 2'b00;
  localparam logic [1:0] C_LR  = 2'b01;
  localparam logic [1:0] C_SC  = 2'b10;
  localparam logic [1:0] C_ILL = 2'b11;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic [1:0]  r_kind;
  logic [9:0]  r_op;
  logic [29:0] r_addr;
  logic [31:0] r_rs2;
  logic [31:0] r_load;
  logic        r_mis;
  logic        r_ill;
  logic        r_sc_fail;

  logic        w_op_onehot;
  logic        w_mis;
  logic        w_ill;
  logic        w_exc;
  logic        w_resv_hit;
  logic        w_sc_fail;
  logic [31:0] w_alu;
  logic [31:0] w_wdata;
  logic [31:0] w_result;

  // ---------------------------------------------------------------------------
  // Start-cycle decode: exceptions and SC reservation check use live inputs
  // ---------------------------------------------------------------------------
  assign w_op_onehot = (amo_op_i != 10'd0) && ((amo_op_i & (amo_op_i - 10'd1)) == 10'd0);
  assign w_mis       = (addr_i[1:0] != 2'b00);

`ifdef RS5_ZALRSC_EN
  assign w_ill = (kind_i == C_ILL) ||
                 ((kind_i == C_AMO) && (!w_op_onehot || amo_op_i[0]));
`else
  // Without LR/SC support only plain AMOs are legal.
  assign w_ill = (kind_i != C_AMO) || !w_op_onehot || amo_op_i[0];
`endif

  assign w_exc     = w_mis | w_ill;
  assign w_sc_fail = (kind_i == C_SC) && !w_resv_hit;

  // ---------------------------------------------------------------------------
  // Reservation tracking
  // ---------------------------------------------------------------------------
`ifdef RS5_ZALRSC_EN
  logic        r_resv_valid;
  logic [29:0] r_resv_addr;
  logic        w_resv_set;
  logic        w_resv_clr;
  logic [29:0] w_resv_tag;
  logic        w_unused_snoop_lo;

  assign w_resv_hit = r_resv_valid && (r_resv_addr == addr_i[31:2]);
  assign w_resv_set = (r_state == C_READ) && (r_kind == C_LR) && mem_ack_i;
  // A snoop in the same cycle as the LR set must compare against the new tag.
  assign w_resv_tag = w_resv_set ? r_addr : r_resv_addr;
  assign w_resv_clr = resv_clear_i ||
                      (snoop_we_i && (snoop_addr_i[31:2] == w_resv_tag)) ||
                      ((r_state == C_RESP) && (r_kind == C_SC));
  assign w_unused_snoop_lo = ^snoop_addr_i[1:0];

  // Reservation register: clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resv_valid <= 1'b0;
      r_resv_addr  <= 30'd0;
    end else begin
      if (w_resv_set) begin
        r_resv_addr <= r_addr;
      end
      if (w_resv_clr) begin
        r_resv_valid <= 1'b0;
      end else if (w_resv_set) begin
        r_resv_valid <= 1'b1;
      end
    end
  end
`else
  logic w_unused_zalrsc;

  assign w_resv_hit      = 1'b0;
  assign w_unused_zalrsc = ^{resv_clear_i, snoop_we_i, snoop_addr_i};
`endif

  // ---------------------------------------------------------------------------
  // AMO ALU: ties in min/max keep the loaded value
  // ---------------------------------------------------------------------------
  always_comb begin
    w_alu = r_rs2;
    if (r_op[2]) begin
      w_alu = r_load + r_rs2;
    end else if (r_op[3]) begin
      w_alu = r_load ^ r_rs2;
    end else if (r_op[4]) begin
      w_alu = r_load & r_rs2;
    end else if (r_op[5]) begin
      w_alu = r_load | r_rs2;
    end else if (r_op[6]) begin
      w_alu = ($signed(r_rs2) < $signed(r_load)) ? r_rs2 : r_load;
    end else if (r_op[7]) begin
      w_alu = ($signed(r_rs2) > $signed(r_load)) ? r_rs2 : r_load;
    end else if (r_op[8]) begin
      w_alu = (r_rs2 < r_load) ? r_rs2 : r_load;
    end else if (r_op[9]) begin
      w_alu = (r_rs2 > r_load) ? r_rs2 : r_load;
    end
  end

  assign w_wdata  = (r_kind == C_SC) ? r_rs2 : w_alu;
  assign w_result = (r_mis || r_ill) ? 32'd0 :
                    (r_kind == C_SC) ? {31'd0, r_sc_fail} : r_load;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: begin
        if (start_i) begin
          if (w_exc) begin
            w_state_nxt = C_RESP;
          end else if (kind_i == C_SC) begin
            w_state_nxt = w_resv_hit ? C_WRITE : C_RESP;
          end else begin
            w_state_nxt = C_READ;
          end
        end
      end
      C_READ: begin
        if (mem_ack_i) begin
          w_state_nxt = (r_kind == C_LR) ? C_RESP : C_WRITE;
        end
      end
      C_WRITE: begin
        if (mem_ack_i) begin
          w_state_nxt = C_RESP;
        end
      end
      default: begin
        w_state_nxt = C_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from state only so they hold steady while waiting
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'd0;
    mem_wdata_o  = 32'd0;
    busy_o       = (r_state != C_IDLE);
    done_o       = 1'b0;
    result_o     = 32'd0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (r_state)
      C_READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_addr, 2'b00};
      end
      C_WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_addr, 2'b00};
        mem_wdata_o = w_wdata;
      end
      C_RESP: begin
        done_o       = 1'b1;
        result_o     = w_result;
        misaligned_o = r_mis;
        illegal_o    = r_ill;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture at start and load capture on read ack
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kind    <= C_AMO;
      r_op      <= 10'd0;
      r_addr    <= 30'd0;
      r_rs2     <= 32'd0;
      r_load    <= 32'd0;
      r_mis     <= 1'b0;
      r_ill     <= 1'b0;
      r_sc_fail <= 1'b0;
    end else if ((r_state == C_IDLE) && start_i) begin
      r_kind    <= kind_i;
      r_op      <= amo_op_i;
      r_addr    <= addr_i[31:2];
      r_rs2     <= rs2_i;
      r_load    <= 32'd0;
      r_mis     <= w_mis;
      r_ill     <= w_ill;
      r_sc_fail <= w_sc_fail;
    end else if ((r_state == C_READ) && mem_ack_i) begin
      r_load    <= mem_rdata_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_amo_controller.sv
// ============================================================================
//  Module      : tb_amo_controller
//  Description : Directed, table-driven bench for amo_controller with a
//                same-cycle-ack memory responder. LR/SC sequences are run
//                when RS5_ZALRSC_EN is defined, the illegal-kind path when not.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_amo_controller;

  localparam logic [1:0] K_AMO = 2'b00;
  localparam logic [1:0] K_LR  = 2'b01;
  localparam logic [1:0] K_SC  = 2'b10;
  localparam logic [1:0] K_BAD = 2'b11;

  localparam logic [9:0] OP_NOP  = 10'h001;
  localparam logic [9:0] OP_SWAP = 10'h002;
  localparam logic [9:0] OP_ADD  = 10'h004;
  localparam logic [9:0] OP_XOR  = 10'h008;
  localparam logic [9:0] OP_AND  = 10'h010;
  localparam logic [9:0] OP_OR   = 10'h020;
  localparam logic [9:0] OP_MIN  = 10'h040;
  localparam logic [9:0] OP_MAX  = 10'h080;
  localparam logic [9:0] OP_MINU = 10'h100;
  localparam logic [9:0] OP_MAXU = 10'h200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  kind_i;
  logic [9:0]  amo_op_i;
  logic [31:0] addr_i;
  logic [31:0] rs2_i;
  logic        resv_clear_i;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        misaligned_o;
  logic        illegal_o;

  logic        rack_en;
  logic        wack_en;

  always #5 clk = ~clk;

  // Memory responder: acknowledges in the same cycle the request appears.
  assign mem_ack_i = mem_req_o & (mem_we_o ? wack_en : rack_en);

  amo_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .kind_i       (kind_i),
    .amo_op_i     (amo_op_i),
    .addr_i       (addr_i),
    .rs2_i        (rs2_i),
    .resv_clear_i (resv_clear_i),
    .snoop_we_i   (snoop_we_i),
    .snoop_addr_i (snoop_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .misaligned_o (misaligned_o),
    .illegal_o    (illegal_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Captured observations of the last transaction
  int          o_lat;
  logic        o_rd;
  logic [31:0] o_rd_addr;
  logic        o_wr;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [31:0] o_res;
  logic        o_mis;
  logic        o_ill;

  typedef struct {
    logic [1:0]  kind;
    logic [9:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] mem;
    int          lat;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] res;
    logic        mis;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation and observe it until done_o (bounded).
  task automatic run_op(input logic [1:0] k, input logic [9:0] op, input logic [31:0] a,
                        input logic [31:0] r2, input logic [31:0] md, input logic clr1);
    logic fin;
    fin = 1'b0;
    o_lat = 0; o_rd = 1'b0; o_wr = 1'b0; o_rd_addr = 32'd0;
    o_wr_addr = 32'd0; o_wr_data = 32'd0; o_res = 32'd0; o_mis = 1'b0; o_ill = 1'b0;
    @(negedge clk);
    kind_i = k; amo_op_i = op; addr_i = a; rs2_i = r2; mem_rdata_i = md; start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20 && !fin; c++) begin
      @(negedge clk);
      start_i      = 1'b0;
      resv_clear_i = (c == 1) ? clr1 : 1'b0;
      #1;
      if (mem_req_o && !mem_we_o) begin o_rd = 1'b1; o_rd_addr = mem_addr_o; end
      if (mem_req_o && mem_we_o)  begin o_wr = 1'b1; o_wr_addr = mem_addr_o; o_wr_data = mem_wdata_o; end
      if (done_o) begin
        fin = 1'b1; o_lat = c; o_res = result_o; o_mis = misaligned_o; o_ill = illegal_o;
      end
    end
    resv_clear_i = 1'b0;
    if (!fin) begin
      n_chk++; n_err++;
      $display("FAIL timeout: got no done_o expected done within 20 cycles");
    end
    @(negedge clk);
    chk("done_pulse", {30'd0, done_o, busy_o}, 32'd0);
  endtask

  task automatic snoop(input logic [31:0] a);
    @(negedge clk);
    snoop_we_i = 1'b1; snoop_addr_i = a;
    @(negedge clk);
    snoop_we_i = 1'b0; snoop_addr_i = 32'd0;
  endtask

  initial begin
    //           kind   op       addr        rs2           mem           lat wr  wdata         res           mis ill
    vecs[0]  = '{K_AMO, OP_ADD,  32'h100,    32'h3,        32'h5,        3, 1, 32'h8,        32'h5,        0, 0};
    vecs[1]  = '{K_AMO, OP_MIN,  32'h104,    32'h1,        32'hFFFFFFFF, 3, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
    vecs[2]  = '{K_AMO, OP_MINU, 32'h104,    32'h1,        32'hFFFFFFFF, 3, 1, 32'h1,        32'hFFFFFFFF, 0, 0};
    vecs[3]  = '{K_AMO, OP_MAX,  32'h108,    32'h1,        32'hFFFFFFFF, 3, 1, 32'h1,        32'hFFFFFFFF, 0, 0};
    vecs[4]  = '{K_AMO, OP_MAXU, 32'h108,    32'h1,        32'hFFFFFFFF, 3, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
    vecs[5]  = '{K_AMO, OP_SWAP, 32'h40,     32'hCAFEBABE, 32'h12345678, 3, 1, 32'hCAFEBABE, 32'h12345678, 0, 0};
    vecs[6]  = '{K_AMO, OP_XOR,  32'hABC0,   32'hFF00FF00, 32'hF0F0F0F0, 3, 1, 32'h0FF00FF0, 32'hF0F0F0F0, 0, 0};
    vecs[7]  = '{K_AMO, OP_AND,  32'hABC4,   32'hFF00FF00, 32'hF0F0F0F0, 3, 1, 32'hF000F000, 32'hF0F0F0F0, 0, 0};
    vecs[8]  = '{K_AMO, OP_OR,   32'hABC8,   32'hFF00FF00, 32'hF0F0F0F0, 3, 1, 32'hFFF0FFF0, 32'hF0F0F0F0, 0, 0};
    vecs[9]  = '{K_AMO, OP_ADD,  32'h8000000C, 32'h2,      32'hFFFFFFFF, 3, 1, 32'h1,        32'hFFFFFFFF, 0, 0};
    vecs[10] = '{K_AMO, OP_SWAP, 32'h102,    32'h9,        32'h77,       1, 0, 32'h0,        32'h0,        1, 0};
    vecs[11] = '{K_AMO, OP_NOP,  32'h100,    32'h9,        32'h77,       1, 0, 32'h0,        32'h0,        0, 1};
    vecs[12] = '{K_AMO, 10'h006, 32'h100,    32'h9,        32'h77,       1, 0, 32'h0,        32'h0,        0, 1};
    vecs[13] = '{K_AMO, 10'h000, 32'h100,    32'h9,        32'h77,       1, 0, 32'h0,        32'h0,        0, 1};
    vecs[14] = '{K_BAD, OP_ADD,  32'h100,    32'h9,        32'h77,       1, 0, 32'h0,        32'h0,        0, 1};

    reset = 1'b1; start_i = 1'b0; kind_i = 2'b00; amo_op_i = 10'd0; addr_i = 32'd0;
    rs2_i = 32'd0; resv_clear_i = 1'b0; snoop_we_i = 1'b0; snoop_addr_i = 32'd0;
    mem_rdata_i = 32'd0; rack_en = 1'b1; wack_en = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {26'd0, mem_req_o, mem_we_o, busy_o, done_o, misaligned_o, illegal_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    reset = 1'b0;

    // Table of AMO / exception vectors
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].kind, vecs[i].op, vecs[i].addr, vecs[i].rs2, vecs[i].mem, 1'b0);
      chk($sformatf("v%0d_lat", i), o_lat, vecs[i].lat);
      chk($sformatf("v%0d_res", i), o_res, vecs[i].res);
      chk($sformatf("v%0d_flags", i), {30'd0, o_mis, o_ill}, {30'd0, vecs[i].mis, vecs[i].ill});
      chk($sformatf("v%0d_req", i), {30'd0, o_rd, o_wr}, {30'd0, vecs[i].wr, vecs[i].wr});
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_raddr", i), o_rd_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_waddr", i), o_wr_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_wdata", i), o_wr_data, vecs[i].wdata);
      end
    end

    // Reset in WRITE with the write ack withheld
    wack_en = 1'b0;
    @(negedge clk);
    kind_i = K_AMO; amo_op_i = OP_ADD; addr_i = 32'h300; rs2_i = 32'h1; mem_rdata_i = 32'h10;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("hold_we", {30'd0, mem_req_o, mem_we_o}, 32'd3);
    repeat (3) @(negedge clk);
    chk("hold_req", {30'd0, mem_req_o, mem_we_o}, 32'd3);
    chk("hold_addr", mem_addr_o, 32'h300);
    chk("hold_wdata", mem_wdata_o, 32'h11);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid", {29'd0, busy_o, mem_req_o, mem_we_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0; wack_en = 1'b1;
    run_op(K_AMO, OP_ADD, 32'h300, 32'h1, 32'h10, 1'b0);
    chk("post_rst_lat", o_lat, 3);
    chk("post_rst_res", o_res, 32'h10);
    chk("post_rst_wdata", o_wr_data, 32'h11);

`ifdef RS5_ZALRSC_EN
    // LR then SC succeeds, second SC fails without memory access
    run_op(K_LR, OP_NOP, 32'h200, 32'h0, 32'h55, 1'b0);
    chk("lr_lat", o_lat, 2);
    chk("lr_res", o_res, 32'h55);
    chk("lr_req", {30'd0, o_rd, o_wr}, 32'd2);
    chk("lr_raddr", o_rd_addr, 32'h200);
    run_op(K_SC, OP_NOP, 32'h200, 32'hAB, 32'h0, 1'b0);
    chk("sc1_lat", o_lat, 2);
    chk("sc1_res", o_res, 32'h0);
    chk("sc1_req", {30'd0, o_rd, o_wr}, 32'd1);
    chk("sc1_waddr", o_wr_addr, 32'h200);
    chk("sc1_wdata", o_wr_data, 32'hAB);
    run_op(K_SC, OP_NOP, 32'h200, 32'hCD, 32'h0, 1'b0);
    chk("sc2_lat", o_lat, 1);
    chk("sc2_res", o_res, 32'h1);
    chk("sc2_req", {30'd0, o_rd, o_wr}, 32'd0);

    // Snoop store to a different word keeps the reservation
    run_op(K_LR, OP_NOP, 32'h200, 32'h0, 32'h1, 1'b0);
    snoop(32'h204);
    run_op(K_SC, OP_NOP, 32'h200, 32'h7, 32'h0, 1'b0);
    chk("snoop_miss_res", o_res, 32'h0);
    chk("snoop_miss_wdata", o_wr_data, 32'h7);

    // Snoop store to the same word kills it
    run_op(K_LR, OP_NOP, 32'h200, 32'h0, 32'h1, 1'b0);
    snoop(32'h203);
    run_op(K_SC, OP_NOP, 32'h200, 32'h7, 32'h0, 1'b0);
    chk("snoop_hit_res", o_res, 32'h1);
    chk("snoop_hit_req", {30'd0, o_rd, o_wr}, 32'd0);

    // resv_clear_i in the LR ack cycle wins over the set
    run_op(K_LR, OP_NOP, 32'h200, 32'h0, 32'h1, 1'b1);
    run_op(K_SC, OP_NOP, 32'h200, 32'h7, 32'h0, 1'b0);
    chk("clr_ack_res", o_res, 32'h1);
    chk("clr_ack_lat", o_lat, 1);
`else
    // Without LR/SC support both kinds are illegal
    run_op(K_LR, OP_NOP, 32'h200, 32'h0, 32'h55, 1'b0);
    chk("lr_ill_flags", {30'd0, o_mis, o_ill}, 32'd1);
    chk("lr_ill_res", o_res, 32'h0);
    chk("lr_ill_lat", o_lat, 1);
    chk("lr_ill_req", {30'd0, o_rd, o_wr}, 32'd0);
    run_op(K_SC, OP_NOP, 32'h200, 32'hAB, 32'h0, 1'b0);
    chk("sc_ill_flags", {30'd0, o_mis, o_ill}, 32'd1);
    chk("sc_ill_req", {30'd0, o_rd, o_wr}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/amo_controller.md
AMO_CONTROLLER -- requirements
Module: amo_controller

Interface
REQ-001 Parameters: none; data width fixed at 32.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  execute stage issues an atomic instruction; sampled only in IDLE.
REQ-005 kind_i  in  2  00 AMO_W, 01 LR_W, 10 SC_W, 11 illegal.
REQ-006 amo_op_i  in  10  one-hot atomic op (NOP, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU); bit0 is NOP.
REQ-007 addr_i / rs2_i  in  32 each  effective address / source operand; captured at start.
REQ-008 resv_clear_i  in  1  trap, xRET or context switch; kills the reservation.
REQ-009 snoop_we_i / snoop_addr_i  in  1 / 32  regular LSU store in progress, and its address.
REQ-010 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1/1/32/32  memory request bus.
REQ-011 mem_ack_i / mem_rdata_i  in  1/32  ack of the current request; read data valid on ack.
REQ-012 busy_o  out  1  high in any non-IDLE state; stalls the pipeline.
REQ-013 done_o  out  1  one-cycle completion pulse.
REQ-014 result_o  out  32  rd writeback value; valid with done_o.
REQ-015 misaligned_o / illegal_o  out  1 each  exception flags; valid with done_o only.

Function
REQ-016 FSM states: IDLE, READ, WRITE, RESP.
REQ-017 IDLE + start_i: latch all inputs.
  - addr_i[1:0]≠0, or kind 11, or AMO with amo_op_i not one-hot or equal to NOP: go to RESP with the matching flag; no memory access.
  - Otherwise AMO/LR go to READ.
  - SC goes to WRITE if the reservation is valid and matches addr[31:2]; else RESP with result 1.
REQ-018 READ: mem_req_o=1, mem_we_o=0, mem_addr_o={addr[31:2],2'b00}; hold until mem_ack_i.
  - On ack, capture rdata into the load register.
  - LR then goes to RESP; AMO goes to WRITE.
REQ-019 WRITE: mem_req_o=1, mem_we_o=1; hold until ack, then go to RESP.
  - mem_wdata_o = rs2 for SC; ALU(load, rs2) for AMO.
REQ-020 AMO ALU: SWAP=rs2; ADD=mod-2^32 sum; XOR/AND/OR bitwise; MIN/MAX signed compare; MINU/MAXU unsigned compare; ties select the loaded value.
REQ-021 RESP: done_o=1 for one cycle, then IDLE.
  - result_o = loaded value for AMO/LR; 0 for successful SC; 1 for failed SC; 0 on exception.
REQ-022 Outputs are stable while mem_req_o is high and ack is low; there is no request timeout.
REQ-023 Latency with same-cycle ack, start to done:
  - AMO: 3 cycles.
  - LR: 2 cycles.
  - SC success: 2 cycles.
  - SC fail or exception: 1 cycle.
REQ-024 Reservation (valid bit + 30-bit word address):
  - Set on LR read ack.
  - Cleared by any SC reaching RESP, resv_clear_i, snoop_we_i with snoop_addr_i[31:2] match, or reset.
REQ-025 Clear has priority over a same-cycle LR set; the reservation ends invalid.
REQ-026 The SC check uses reservation state at the start cycle; a later clear does not abort a write already issued.
REQ-027 start_i outside IDLE is ignored; the block never accepts a second operation before done_o.

Reset
REQ-028 Reset forces IDLE immediately, including mid-transaction; the abandoned request is not completed.
REQ-029 Reset values: mem_req_o=0, mem_we_o=0, busy_o=0, done_o=0, all flags 0, result_o=0, mem_addr_o=0, mem_wdata_o=0, reservation invalid.

Configuration
REQ-030 Macro RS5_ZALRSC_EN selects LR/SC support.
  - Defined: LR/SC behave per REQ-017..026.
  - Undefined: reservation logic is absent; kind 01/10 is treated as illegal (RESP, illegal_o=1, result 0, no memory access); AMO is unaffected.

Verification
REQ-031 AMOADD, addr 0x100, mem 0x5, rs2 0x3, ack same cycle:
  - read 0x100, then write 0x8 to 0x100.
  - result 0x5; done_o on cycle 3.
REQ-032 AMOMIN, mem 0xFFFFFFFF, rs2 0x1: writes 0xFFFFFFFF. AMOMINU, same operands: writes 0x1.
REQ-033 LR 0x200, then SC 0x200 rs2 0xAB: SC writes 0xAB with result 0. Second SC 0x200: result 1, no memory request.
REQ-034 LR 0x200, then snoop store to 0x203, then SC 0x200: result 1. Repeat with resv_clear_i in the LR ack cycle: SC result 1.
REQ-035 AMOSWAP at 0x102: misaligned_o=1, done_o after 1 cycle, mem_req_o never asserted.
REQ-036 Two further cases:
  - Reset asserted during WRITE with ack withheld: busy_o and mem_req_o drop immediately; the next AMO completes normally.
  - Without RS5_ZALRSC_EN: LR gives illegal_o=1.
